// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: port ids, counter width,
// response-stage record and the address legality check.
package dmem_arbiter_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STAT_W = 16;

  // Requester identity carried down the pipeline with each access.
  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DMA = 1'b1
  } port_e;

  // Response stage contents.
  typedef struct packed {
    logic              valid;
    port_e             port;
    logic              err;
    logic [DATA_W-1:0] rdata;
  } rsp_stage_t;

  // Misaligned or past-the-end byte address. Callers zero-extend the address to
  // 64 bits so the range compare cannot wrap for any address width up to 64.
  function automatic logic addr_err(input logic [63:0] addr, input logic [63:0] limit);
    return (addr[1:0] != 2'b00) || (addr >= limit);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the data-memory arbiter: two request/response ports plus the
// single memory port. 'slave' is the arbiter view; 'master' is the view of the
// requesters and the memory.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);

  // Port 0 (CPU MEM stage)
  logic              req0_valid_i;
  logic              req0_we_i;
  logic [ADDR_W-1:0] req0_addr_i;
  logic [31:0]       req0_wdata_i;
  logic              req0_ready_o;
  logic              rsp0_valid_o;
  logic              rsp0_err_o;
  logic [31:0]       rsp0_rdata_o;

  // Port 1 (DMA / debug loader)
  logic              req1_valid_i;
  logic              req1_we_i;
  logic [ADDR_W-1:0] req1_addr_i;
  logic [31:0]       req1_wdata_i;
  logic              req1_ready_o;
  logic              rsp1_valid_o;
  logic              rsp1_err_o;
  logic [31:0]       rsp1_rdata_o;

  // Memory port
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_read_o;
  logic              mem_write_o;
  logic [31:0]       mem_wdata_o;
  logic [31:0]       mem_rdata_i;

  modport slave (
    input  req0_valid_i, req0_we_i, req0_addr_i, req0_wdata_i,
    output req0_ready_o, rsp0_valid_o, rsp0_err_o, rsp0_rdata_o,
    input  req1_valid_i, req1_we_i, req1_addr_i, req1_wdata_i,
    output req1_ready_o, rsp1_valid_o, rsp1_err_o, rsp1_rdata_o,
    output mem_addr_o, mem_read_o, mem_write_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output req0_valid_i, req0_we_i, req0_addr_i, req0_wdata_i,
    input  req0_ready_o, rsp0_valid_o, rsp0_err_o, rsp0_rdata_o,
    output req1_valid_i, req1_we_i, req1_addr_i, req1_wdata_i,
    input  req1_ready_o, rsp1_valid_o, rsp1_err_o, rsp1_rdata_o,
    input  mem_addr_o, mem_read_o, mem_write_o, mem_wdata_o,
    output mem_rdata_i
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin grant with its priority pointer. The pointer names the
// port that wins a tie; after every grant it moves to the port that did not win.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] valid_i,
  output logic [1:0] grant_o,
  input  logic       advance_i
);

  logic r_ptr;  // 0: port 0 wins a tie, 1: port 1 wins a tie

  // One-hot grant: a lone requester always wins, a tie goes to the pointer.
  always_comb begin
    grant_o = valid_i;
    if (valid_i == 2'b11) begin
      grant_o = r_ptr ? 2'b10 : 2'b01;
    end
  end

  // Pointer update: favour the loser of this grant next time.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr <= 1'b0;
    end else if (advance_i) begin
      r_ptr <= grant_o[0];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the shared data memory.
// Accepted requests go to stage C (drives the memory port for one cycle), then
// to stage R (one-cycle response pulse on the owning port). Misaligned or
// out-of-range accesses never reach memory and get an error response.
// Optional build macro DMEM_ARB_STATS_EN adds saturating per-port accept counters.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 32,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  dmem_arbiter_if.slave       bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]   stat0_cnt_o,
  output logic [STAT_W-1:0]   stat1_cnt_o
`endif
);

  // First illegal byte address; computed in 64 bits so it never wraps.
  localparam logic [63:0] MEM_LIMIT = 64'(MEM_WORDS) * 64'd4;

  logic [1:0]        w_valid;
  logic [1:0]        w_grant;
  logic              w_accept;
  port_e             w_sel_port;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [31:0]       w_sel_wdata;
  logic              w_sel_err;

  logic              r_c_valid;
  port_e             r_c_port;
  logic              r_c_we;
  logic              r_c_err;
  logic [ADDR_W-1:0] r_c_addr;
  logic [31:0]       r_c_wdata;
  logic              w_c_live;

  rsp_stage_t        r_r;
  logic              w_r_own0;
  logic              w_r_own1;

  assign w_valid  = {bus.req1_valid_i, bus.req0_valid_i};
  assign w_accept = |w_grant;

  rr_arb2 u_rr_arb2 (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   (w_valid),
    .grant_o   (w_grant),
    .advance_i (w_accept)
  );

  assign bus.req0_ready_o = w_grant[0];
  assign bus.req1_ready_o = w_grant[1];

  // Select the granted request and run the legality check on it.
  always_comb begin
    w_sel_port  = PORT_CPU;
    w_sel_we    = bus.req0_we_i;
    w_sel_addr  = bus.req0_addr_i;
    w_sel_wdata = bus.req0_wdata_i;
    if (w_grant[1]) begin
      w_sel_port  = PORT_DMA;
      w_sel_we    = bus.req1_we_i;
      w_sel_addr  = bus.req1_addr_i;
      w_sel_wdata = bus.req1_wdata_i;
    end
    w_sel_err = addr_err(64'(w_sel_addr), MEM_LIMIT);
  end

  // Stage C: register the accepted request; payload only loads on accept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_c_valid <= 1'b0;
      r_c_port  <= PORT_CPU;
      r_c_we    <= 1'b0;
      r_c_err   <= 1'b0;
      r_c_addr  <= '0;
      r_c_wdata <= '0;
    end else begin
      r_c_valid <= w_accept;
      if (w_accept) begin
        r_c_port  <= w_sel_port;
        r_c_we    <= w_sel_we;
        r_c_err   <= w_sel_err;
        r_c_addr  <= w_sel_addr;
        r_c_wdata <= w_sel_wdata;
      end
    end
  end

  // Memory port is quiet (all zero) unless stage C holds a legal access. Reset
  // clears stage C asynchronously, so a write in flight drops before it commits.
  assign w_c_live        = r_c_valid & ~r_c_err;
  assign bus.mem_read_o  = w_c_live & ~r_c_we;
  assign bus.mem_write_o = w_c_live & r_c_we;
  assign bus.mem_addr_o  = w_c_live ? r_c_addr : '0;
  assign bus.mem_wdata_o = w_c_live ? r_c_wdata : '0;

  // Stage R: capture read data at the end of the memory cycle; writes and
  // errors return zero data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_r <= '0;
    end else begin
      r_r.valid <= r_c_valid;
      r_r.port  <= r_c_port;
      r_r.err   <= r_c_err;
      r_r.rdata <= bus.mem_read_o ? bus.mem_rdata_i : '0;
    end
  end

  assign w_r_own0 = r_r.valid & (r_r.port == PORT_CPU);
  assign w_r_own1 = r_r.valid & (r_r.port == PORT_DMA);

  assign bus.rsp0_valid_o = w_r_own0;
  assign bus.rsp0_err_o   = w_r_own0 & r_r.err;
  assign bus.rsp0_rdata_o = w_r_own0 ? r_r.rdata : '0;
  assign bus.rsp1_valid_o = w_r_own1;
  assign bus.rsp1_err_o   = w_r_own1 & r_r.err;
  assign bus.rsp1_rdata_o = w_r_own1 ? r_r.rdata : '0;

`ifdef DMEM_ARB_STATS_EN
  logic [STAT_W-1:0] r_stat0;
  logic [STAT_W-1:0] r_stat1;

  // Saturating accept counters; errored accepts count as well.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stat0 <= '0;
      r_stat1 <= '0;
    end else begin
      if (w_grant[0] && (r_stat0 != '1)) begin
        r_stat0 <= r_stat0 + STAT_W'(1);
      end
      if (w_grant[1] && (r_stat1 != '1)) begin
        r_stat1 <= r_stat1 + STAT_W'(1);
      end
    end
  end

  assign stat0_cnt_o = r_stat0;
  assign stat1_cnt_o = r_stat1;
`endif

endmodule
